// File: rtl/if_prefetch_pkg.sv
// Shared constants for the instruction prefetcher (fetch step, alignment, default depth).
package if_prefetch_pkg;

  localparam int IF_FIFO_DEPTH   = 4;
  localparam int INST_ALIGN_MASK = 3;
  localparam int PC_INC          = 4;

endpackage

// File: rtl/if_prefetch_if.sv
// Instruction-bus and ID-side signals of the prefetcher, grouped for one port.
// Handshakes: a fetch is accepted in a cycle with req_o & gnt_i; rvalid_i returns
// one in-order word per accepted fetch; an instruction moves to ID on ins_valid_o & ins_ready_i.
interface if_prefetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_o;
  logic [ADDR_W-1:0] req_addr_o;
  logic              gnt_i;
  logic              rvalid_i;
  logic [DATA_W-1:0] rdata_i;
  logic              ins_valid_o;
  logic              ins_ready_i;
  logic [DATA_W-1:0] ins_o;
  logic [ADDR_W-1:0] ins_addr_o;

  modport master (
    output req_o, req_addr_o, ins_valid_o, ins_o, ins_addr_o,
    input  gnt_i, rvalid_i, rdata_i, ins_ready_i
  );

  modport slave (
    input  req_o, req_addr_o, ins_valid_o, ins_o, ins_addr_o,
    output gnt_i, rvalid_i, rdata_i, ins_ready_i
  );
endinterface

// File: rtl/if_prefetch_fifo.sv
// if_fifo: synchronous FIFO, power-of-two depth; flush wins over push and pop.
module if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_eff, pop_eff;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO is only taken when the same cycle frees the head slot.
  assign pop_eff  = pop & ~empty & ~flush;
  assign push_eff = push & (~full | pop_eff) & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_eff) - CW'(pop_eff);
    if (push_eff) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_eff)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/if_prefetch.sv
// Decoupled instruction prefetcher: credit-limited sequential fetch, FIFO to ID, jump squash.
// Optional IF_PREFETCH_PERF_EN adds saturating fetch/squash/stall counters.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter int              FIFO_DEPTH = IF_FIFO_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  if_prefetch_if.master     bus
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_o,
  output logic [31:0]       perf_squash_o,
  output logic [31:0]       perf_stall_o
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INST_ALIGN_MASK);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     discard_q, discard_d;

  logic [ADDR_W-1:0] jump_target;
  logic              credit_ok, req, accept, resp, drop, keep;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [ADDR_W+DATA_W-1:0] fifo_head;

  assign jump_target = jump_addr_i & ALIGN_MASK;

  // In-flight plus buffered words never exceed the FIFO, so every kept response has a slot.
  assign credit_ok = ({1'b0, outst_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
  assign req       = ~rst & ~jump_flag_i & credit_ok;
  assign accept    = req & bus.gnt_i;
  assign resp      = bus.rvalid_i & (outst_q != '0);
  assign drop      = resp & (discard_q != '0);
  assign keep      = resp & ~drop;

  assign fifo_push = keep & ~jump_flag_i;
  assign fifo_pop  = bus.ins_valid_o & bus.ins_ready_i;

  assign bus.req_o       = req;
  assign bus.req_addr_o  = fetch_pc_q;
  assign bus.ins_valid_o = ~fifo_empty & ~jump_flag_i;
  assign bus.ins_addr_o  = fifo_empty ? '0 : fifo_head[ADDR_W+DATA_W-1:DATA_W];
  assign bus.ins_o       = fifo_empty ? '0 : fifo_head[DATA_W-1:0];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q + CW'(accept) - CW'(resp);
    discard_d  = discard_q;
    if (accept) fetch_pc_d = fetch_pc_q + PC_STEP;
    if (drop)   discard_d  = discard_q - CW'(1);
    if (keep)   resp_pc_d  = resp_pc_q + PC_STEP;
    // Every response still owed after this cycle belongs to the old stream.
    if (jump_flag_i) begin
      fetch_pc_d = jump_target;
      resp_pc_d  = jump_target;
      discard_d  = outst_q - CW'(resp);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  if_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (jump_flag_i),
    .wdata ({resp_pc_q, bus.rdata_i}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full && !fifo_pop));

`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_squash_q, perf_squash_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        squash_ev, stall_ev;

  // A response arriving in a jump cycle is squashed even when discard was zero.
  assign squash_ev = drop | (keep & jump_flag_i);
  assign stall_ev  = bus.ins_ready_i & fifo_empty & ~jump_flag_i;

  always_comb begin
    perf_fetch_d  = perf_fetch_q;
    perf_squash_d = perf_squash_q;
    perf_stall_d  = perf_stall_q;
    if (accept    && perf_fetch_q  != '1) perf_fetch_d  = perf_fetch_q  + 32'd1;
    if (squash_ev && perf_squash_q != '1) perf_squash_d = perf_squash_q + 32'd1;
    if (stall_ev  && perf_stall_q  != '1) perf_stall_d  = perf_stall_q  + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q  <= '0;
      perf_squash_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_fetch_q  <= perf_fetch_d;
      perf_squash_q <= perf_squash_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_fetch_o  = perf_fetch_q;
  assign perf_squash_o = perf_squash_q;
  assign perf_stall_o  = perf_stall_q;
`endif
endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: in-order bus model with random latency, expected stream queue, monitor.
module tb_if_prefetch;
  localparam int          ADDR_W   = 32;
  localparam int          DATA_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;

  if_prefetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] perf_fetch, perf_squash, perf_stall;
`endif

  if_prefetch #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .jump_flag_i (jump_flag_i),
    .jump_addr_i (jump_addr_i),
    .bus         (bus)
`ifdef IF_PREFETCH_PERF_EN
    ,
    .perf_fetch_o  (perf_fetch),
    .perf_squash_o (perf_squash),
    .perf_stall_o  (perf_stall)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_next, exp_req;
  int vectors = 0, miscompares = 0;
  int cyc = 0, last_due = 0;
  int gnt_pct = 0, rdy_pct = 0, lat_lo = 1, lat_hi = 1;
  int gnt_cnt = 0, pop_cnt = 0, accept_total = 0;
  int first_gnt = -1, first_valid = -1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.gnt_i = 1'b0; bus.rvalid_i = 1'b0; bus.ins_ready_i = 1'b0;
    jump_flag_i = 1'b0;
    pend_q.delete();
    exp_q.delete();
    exp_next = RESET_PC;
    exp_req  = RESET_PC;
    accept_total = 0;
    #1;
    check("rst_req_o",       64'(bus.req_o),       64'd0);
    check("rst_ins_valid_o", 64'(bus.ins_valid_o), 64'd0);
    check("rst_ins_o",       64'(bus.ins_o),       64'd0);
    check("rst_ins_addr_o",  64'(bus.ins_addr_o),  64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- driver: bus model + ID-side stimulus ----------------
  task automatic drive_cycle(input bit jmp, input logic [31:0] jaddr);
    int    lat, due;
    pend_t p;
    @(posedge clk);
    cyc++;
    #1;
    bus.gnt_i       = ($urandom_range(0, 99) < gnt_pct);
    bus.ins_ready_i = ($urandom_range(0, 99) < rdy_pct);
    jump_flag_i     = jmp;
    jump_addr_i     = jaddr;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      bus.rvalid_i = 1'b1;
      bus.rdata_i  = mem_word(pend_q[0].addr);
    end else begin
      bus.rvalid_i = 1'b0;
      bus.rdata_i  = $urandom;
    end
    // A redirect restarts the expected stream at the aligned target.
    if (jmp) begin
      exp_q.delete();
      exp_next = jaddr & ~32'h3;
      exp_req  = exp_next;
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back({exp_next, mem_word(exp_next)});
      exp_next += 32'd4;
    end
    @(negedge clk);
    if (jmp) begin
      check("jump_req_low",   64'(bus.req_o),       64'd0);
      check("jump_valid_low", 64'(bus.ins_valid_o), 64'd0);
    end
    if (bus.rvalid_i) p = pend_q.pop_front();
    if (bus.req_o && bus.gnt_i) begin
      check("req_addr", 64'(bus.req_addr_o), 64'(exp_req));
      exp_req += 32'd4;
      gnt_cnt++;
      accept_total++;
      if (first_gnt < 0) first_gnt = cyc;
      lat = $urandom_range(lat_lo, lat_hi);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_q.push_back('{bus.req_addr_o, due});
    end
    if (bus.ins_valid_o && first_valid < 0) first_valid = cyc;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.ins_valid_o && bus.ins_ready_i) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("stream", {bus.ins_addr_o, bus.ins_o}, e);
        end
        pop_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- tests ----------------
  initial begin
    int p0;
    bus.gnt_i = 1'b0; bus.rvalid_i = 1'b0; bus.rdata_i = '0; bus.ins_ready_i = 1'b0;

    // Sequential fetch, 1-cycle bus, always ready.
    apply_reset();
    gnt_pct = 100; rdy_pct = 100; lat_lo = 1; lat_hi = 1;
    first_gnt = -1; first_valid = -1;
    repeat (10) drive_cycle(1'b0, '0);
    check("grant_to_valid", 64'(first_valid - first_gnt), 64'd2);
    #1 p0 = pop_cnt;
    repeat (10) drive_cycle(1'b0, '0);
    #1 check("throughput", 64'(pop_cnt - p0), 64'd10);

    // ID stalled: credit stops fetch at DEPTH, then drain in order.
    apply_reset();
    gnt_pct = 100; rdy_pct = 0; gnt_cnt = 0;
    repeat (12) drive_cycle(1'b0, '0);
    check("grants_blocked",  64'(gnt_cnt),         64'(DEPTH));
    check("req_low_full",    64'(bus.req_o),       64'd0);
    check("valid_held_full", 64'(bus.ins_valid_o), 64'd1);
    #1 p0 = pop_cnt;
    rdy_pct = 100;
    repeat (4) drive_cycle(1'b0, '0);
    #1 check("drain_count", 64'(pop_cnt - p0), 64'(DEPTH));

    // Jump to an unaligned target with two fetches in flight and a response in the jump cycle.
    apply_reset();
    gnt_pct = 100; rdy_pct = 100; lat_lo = 2; lat_hi = 2;
    repeat (8) drive_cycle(1'b0, '0);
    check("inflight_before_jump", 64'(pend_q.size()), 64'd2);
    lat_lo = 1; lat_hi = 1;
    drive_cycle(1'b1, 32'h103);
    drive_cycle(1'b0, '0);
    check("jump_n1_valid",    64'(bus.ins_valid_o), 64'd0);
    check("jump_n1_req",      64'(bus.req_o),       64'd1);
    check("jump_n1_req_addr", 64'(bus.req_addr_o),  64'h100);
    drive_cycle(1'b0, '0);
    check("jump_n2_valid",    64'(bus.ins_valid_o), 64'd0);
    drive_cycle(1'b0, '0);
    check("jump_n3_valid",    64'(bus.ins_valid_o), 64'd1);
    check("jump_n3_addr",     64'(bus.ins_addr_o),  64'h100);

    // Random bus latency, grants, ID stalls and occasional redirects.
    apply_reset();
    gnt_pct = 70; rdy_pct = 70; lat_lo = 1; lat_hi = 5;
    #1 p0 = pop_cnt;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 63) == 0) drive_cycle(1'b1, $urandom);
      else                            drive_cycle(1'b0, '0);
    end
    gnt_pct = 100; rdy_pct = 100;
    repeat (20) drive_cycle(1'b0, '0);
    #1 check("random_progress", 64'(pop_cnt - p0 > 100), 64'd1);

    // Back-to-back jumps: only the second target is fetched.
    lat_lo = 1; lat_hi = 3;
    drive_cycle(1'b1, 32'h40);
    drive_cycle(1'b1, 32'h80);
    #1 p0 = pop_cnt;
    repeat (12) drive_cycle(1'b0, '0);
    #1 check("double_jump_progress", 64'(pop_cnt - p0 > 0), 64'd1);

`ifdef IF_PREFETCH_PERF_EN
    check("perf_fetch", 64'(perf_fetch), 64'(accept_total));
`endif

    // Reset with buffered words and fetches outstanding.
    apply_reset();
    gnt_pct = 100; rdy_pct = 0; lat_lo = 4; lat_hi = 4;
    repeat (6) drive_cycle(1'b0, '0);
    check("mid_valid_before_rst", 64'(bus.ins_valid_o), 64'd1);
    apply_reset();
    rdy_pct = 100; lat_lo = 1; lat_hi = 1;
    drive_cycle(1'b0, '0);
    check("post_rst_req",      64'(bus.req_o),      64'd1);
    check("post_rst_req_addr", 64'(bus.req_addr_o), 64'(RESET_PC));
    repeat (6) drive_cycle(1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
